x_echo_tester: RTL
==================

# x_echo_tester

Link initiator for the UART echo path. The block transmits a configurable number of pattern bytes over its own UART transmitter, waits for each byte to come back on its receiver, and compares it. It reports the mismatch count, a timeout flag and a pass/fail result. It sits on the far end of a serial echo device, on a bring-up board or in a loopback bench, and drives that device's RX pin while listening to its TX pin.

## Interface
- p_clk_hz, 12000000, system clock frequency in Hz.
- p_baud, 115200, UART baud rate.
- p_timeout_bytes, 4, echo timeout expressed in byte times (10 bit times each).
- p_seed, 8'hA5, first pattern byte.

- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_start  in  1  single-cycle start request; sampled only in IDLE.
- i_count  in  16  number of bytes in the run; sampled with i_start.
- i_rx  in  1  serial input, carrying the echo returned by the far end.
- o_tx  out  1  serial output toward the far end.
- o_busy  out  1  run in progress.
- o_done  out  1  one-cycle pulse at the end of a run.
- o_pass  out  1  result of the last run: 1 when there were no mismatches and no timeout.
- o_err_count  out  16  mismatches plus timeouts in the last run; saturates at 16'hFFFF.
- o_timeout  out  1  the last run aborted on timeout.

## Operation
- Contains one x_uart_tx and one x_uart_rx, both using p_clk_hz and p_baud. Their active-high reset is driven by ~i_rst.
- Stop-and-wait: at most one byte is outstanding at any time.
- FSM states:
  - IDLE:
    - i_start with i_count != 0: load remaining = i_count, cur = p_seed, clear o_err_count and o_timeout, go to SEND.
    - i_start with i_count == 0: clear the results and go straight to DONE.
  - SEND: tx i_valid = 1, i_data = cur. On o_accept, clear the timeout counter and go to WAIT.
  - WAIT:
    - On rx o_valid, compare the received byte with cur. On mismatch, increment o_err_count (saturating).
    - Then advance cur, decrement remaining, and go to DONE if remaining hits 0, otherwise go to SEND.
    - If the timeout counter reaches its limit first: set o_timeout, increment o_err_count, and go to DONE. Remaining bytes are abandoned.
  - DONE: o_done = 1 for this cycle, o_pass = (o_err_count == 0) && !o_timeout, then go to IDLE.
- Timeout limit = p_timeout_bytes * 10 * (p_clk_hz / p_baud), using integer division. With the default parameters this is 4160 cycles. The counter is sized with $clog2(limit + 1).
- rx o_valid outside WAIT is ignored and not counted.
- i_start outside IDLE is ignored.
- o_pass, o_err_count and o_timeout hold their values until the next accepted i_start.
- Pattern advance is either the LFSR or an increment; see Configuration. With seed 8'h00 the LFSR sequence stays at 0; this is legal.

## Timing
- Reset values: o_tx = 1, o_busy = 0, o_done = 0, o_pass = 0, o_err_count = 0, o_timeout = 0. The FSM resets to IDLE.
- i_start sampled high at edge N puts the FSM in SEND (or DONE) after that edge. o_busy is high from the cycle following edge N.
- o_busy is 1 in SEND, WAIT and DONE; it is 0 in IDLE.
- tx i_valid is asserted combinationally in SEND and is held until o_accept. i_data stays stable while i_valid is asserted.
- The timeout counter starts at 0 in the first WAIT cycle and increments once per cycle. Timeout fires on the cycle the counter equals the limit.
- If echo arrival and the timeout limit occur in the same cycle, the echo wins: the byte is compared and no timeout is recorded.
- The result outputs update on the edge entering DONE, so they are valid in the same cycle as o_done.
- i_count == 0: o_done pulses 2 cycles after i_start with o_pass = 1 and o_err_count = 0.
- Reset asserted mid-run returns the block to reset values at the next edge. Any partially sent serial byte is cut and o_tx returns to 1.

## Configuration
- X_ECHO_TESTER_LFSR_EN defined: the pattern advances as an 8-bit Galois LFSR, next = (cur >> 1) ^ (cur[0] ? 8'hB8 : 8'h00). The sequence from A5 is A5, EA, 75.
- X_ECHO_TESTER_LFSR_EN undefined: the pattern advances as cur + 1 modulo 256. The sequence from A5 is A5, A6, A7, and FF wraps to 00.

## Test plan
- Clean echo (o_tx looped through an echo device to i_rx), LFSR on, i_count = 3 -> bytes A5, EA, 75 on o_tx; o_done once; o_pass = 1, o_err_count = 0, o_timeout = 0.
- Bench echo flips bit 0 of the 2nd byte, i_count = 3 -> all 3 bytes sent; o_err_count = 1, o_pass = 0, o_timeout = 0.
- No echo, i_count = 5, defaults -> 1 byte sent; timeout 4160 cycles after accept; o_timeout = 1, o_err_count = 1, o_pass = 0.
- i_count = 0 -> o_done pulses 2 cycles after i_start; o_pass = 1; o_tx stays 1 throughout.
- LFSR off, p_seed = 8'hFE, i_count = 3, clean echo -> bytes FE, FF, 00; o_pass = 1. Check also that a second i_start mid-run is ignored.
- Reset asserted during the 2nd byte's start bit -> o_tx = 1 and o_busy = 0 next cycle. A new run after reset completes with o_pass = 1.

Source files
------------

// File: rtl/x_echo_tester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : x_echo_tester (with x_uart_tx, x_uart_rx)                  |
// | Description : UART echo-path link initiator. Sends a pattern of bytes,   |
// |               waits for each echo (stop-and-wait), compares it, and      |
// |               reports mismatches, a timeout flag and a pass/fail result. |
// | Options     : X_ECHO_TESTER_LFSR_EN - pattern advances as an 8-bit       |
// |               Galois LFSR (taps 8'hB8); otherwise it increments.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

// UART transmitter: 8N1, LSB first, accepts a byte only while idle.
module x_uart_tx #(
  parameter int p_clk_hz = 12000000,
  parameter int p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic       o_tx
);
  localparam int c_div = p_clk_hz / p_baud;
  localparam int c_cw  = $clog2(c_div);
  localparam logic [c_cw-1:0] c_last = c_cw'(c_div - 1);

  logic            r_busy;
  logic            r_tx;
  logic [8:0]      r_shift;   // data bits then stop bit, shifted out LSB first
  logic [3:0]      r_bit;
  logic [c_cw-1:0] r_baud;

  assign o_accept = i_valid && !r_busy;
  assign o_tx     = r_tx;

  // Bit timing and shift-out; the start bit is driven on the accept edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
      r_shift <= 9'h1FF;
      r_bit   <= 4'd0;
      r_baud  <= '0;
    end else if (!r_busy) begin
      if (i_valid) begin
        r_busy  <= 1'b1;
        r_tx    <= 1'b0;
        r_shift <= {1'b1, i_data};
        r_bit   <= 4'd0;
        r_baud  <= '0;
      end
    end else if (r_baud == c_last) begin
      r_baud <= '0;
      if (r_bit == 4'd9) begin
        r_busy <= 1'b0;
        r_tx   <= 1'b1;
      end else begin
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
        r_bit   <= r_bit + 4'd1;
      end
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end
endmodule

// UART receiver: 8N1, samples mid-bit, drops frames with a bad start or stop.
module x_uart_rx #(
  parameter int p_clk_hz = 12000000,
  parameter int p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data
);
  localparam int c_div = p_clk_hz / p_baud;
  localparam int c_cw  = $clog2(c_div);
  localparam logic [c_cw-1:0] c_last = c_cw'(c_div - 1);
  localparam logic [c_cw-1:0] c_half = c_cw'(c_div / 2);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_busy;
  logic            r_valid;
  logic [3:0]      r_bit;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]      r_data;
  logic [c_cw-1:0] r_cnt;

  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Input synchroniser plus mid-bit sampling state machine.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_bit   <= 4'd0;
      r_data  <= 8'h00;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      if (!r_busy) begin
        if (!r_sync2) begin
          r_busy <= 1'b1;
          r_cnt  <= c_half;
          r_bit  <= 4'd0;
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= c_last;
        if (r_bit == 4'd0) begin
          if (r_sync2) r_busy <= 1'b0;   // glitch, not a real start bit
          else         r_bit  <= 4'd1;
        end else if (r_bit == 4'd9) begin
          r_busy  <= 1'b0;
          r_valid <= r_sync2;
        end else begin
          r_data <= {r_sync2, r_data[7:1]};
          r_bit  <= r_bit + 4'd1;
        end
      end
    end
  end
endmodule

// Echo tester top level.
module x_echo_tester #(
  parameter int         p_clk_hz        = 12000000,
  parameter int         p_baud          = 115200,
  parameter int         p_timeout_bytes = 4,
  parameter logic [7:0] p_seed          = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_count,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [15:0] o_err_count,
  output logic        o_timeout
);
  localparam int c_div   = p_clk_hz / p_baud;
  localparam int c_limit = p_timeout_bytes * 10 * c_div;
  localparam int c_tw    = $clog2(c_limit + 1);
  localparam logic [c_tw-1:0] c_limit_w = c_tw'(c_limit);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [15:0]     r_remaining;
  logic [7:0]      r_cur;
  logic [15:0]     r_err;
  logic            r_to;
  logic            r_pass;
  logic [c_tw-1:0] r_tmo_cnt;

  logic        w_rst_hi;
  logic        w_tx_valid;
  logic        w_tx_accept;
  logic        w_rx_valid;
  logic [7:0]  w_rx_data;
  logic [7:0]  w_next_pat;
  logic [15:0] w_err_inc;
  logic [15:0] w_err_nx;

  assign w_rst_hi   = ~i_rst;
  assign w_tx_valid = (r_state == S_SEND);

`ifdef X_ECHO_TESTER_LFSR_EN
  assign w_next_pat = (r_cur >> 1) ^ (r_cur[0] ? 8'hB8 : 8'h00);
`else
  assign w_next_pat = r_cur + 8'd1;
`endif

  // Error count saturates rather than wrapping to zero (which would read as a pass).
  assign w_err_inc = (r_err == 16'hFFFF) ? r_err : (r_err + 16'd1);
  assign w_err_nx  = (w_rx_data != r_cur) ? w_err_inc : r_err;

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_pass      = r_pass;
  assign o_err_count = r_err;
  assign o_timeout   = r_to;

  x_uart_tx #(
    .p_clk_hz (p_clk_hz),
    .p_baud   (p_baud)
  ) u_tx (
    .i_clk    (i_clk),
    .i_rst    (w_rst_hi),
    .i_valid  (w_tx_valid),
    .i_data   (r_cur),
    .o_accept (w_tx_accept),
    .o_tx     (o_tx)
  );

  x_uart_rx #(
    .p_clk_hz (p_clk_hz),
    .p_baud   (p_baud)
  ) u_rx (
    .i_clk   (i_clk),
    .i_rst   (w_rst_hi),
    .i_rx    (i_rx),
    .o_valid (w_rx_valid),
    .o_data  (w_rx_data)
  );

  // Run control: one byte outstanding at a time; echo beats timeout on a tie.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= 16'd0;
      r_cur       <= p_seed;
      r_err       <= 16'd0;
      r_to        <= 1'b0;
      r_pass      <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_err  <= 16'd0;
            r_to   <= 1'b0;
            r_pass <= (i_count == 16'd0);
            if (i_count == 16'd0) begin
              r_state <= S_DONE;
            end else begin
              r_remaining <= i_count;
              r_cur       <= p_seed;
              r_state     <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (w_tx_accept) begin
            r_tmo_cnt <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_rx_valid) begin
            r_err       <= w_err_nx;
            r_cur       <= w_next_pat;
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              r_pass  <= (w_err_nx == 16'd0);
              r_state <= S_DONE;
            end else begin
              r_state <= S_SEND;
            end
          end else if (r_tmo_cnt == c_limit_w) begin
            r_to    <= 1'b1;
            r_err   <= w_err_inc;
            r_pass  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire
